// File: rtl/reg_display_source.sv
// Register-file viewer: reads the register selected by the buttons over a
// req/ack handshake, re-reads it periodically, and formats it for the display.
module reg_display_source #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned REFRESH_CYC = 1000000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [15:0]       rd_data,
    output logic [31:0]       seg,
    output logic              err
);
    localparam int RCW = (REFRESH_CYC > 2) ? $clog2(REFRESH_CYC) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, UPDATE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              up_q, dn_q, pending, tmo, upd_q;
    logic [RCW-1:0]    rcnt;
    logic [TCW-1:0]    tcnt;
    logic [15:0]       hold;
    logic              up_e, dn_e, idx_chg, rfsh_hit, launch, ack_hit, tmo_hit;

    assign up_e     = btn_up & ~up_q;
    assign dn_e     = btn_down & ~dn_q;
    assign idx_chg  = up_e ^ dn_e;
    assign rfsh_hit = (state == IDLE) && (rcnt == RCW'(REFRESH_CYC - 1));

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: if (pending) begin
                launch    = 1'b1;
                state_nxt = REQ;
            end
            REQ: if (rd_ack) begin
                ack_hit   = 1'b1;
                state_nxt = UPDATE;
            end else if (tcnt == TCW'(TIMEOUT_CYC - 1)) begin
                tmo_hit   = 1'b1;
                state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            up_q    <= btn_up;
            dn_q    <= btn_down;
            idx     <= '0;
            pending <= 1'b1;
            rcnt    <= '0;
            tcnt    <= '0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            hold    <= '0;
            tmo     <= 1'b0;
            upd_q   <= 1'b0;
            seg     <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            up_q  <= btn_up;
            dn_q  <= btn_down;
            upd_q <= (state == UPDATE);

            if (up_e && !dn_e)      idx <= idx + ADDR_W'(1);
            else if (dn_e && !up_e) idx <= idx - ADDR_W'(1);

            // a set in the launch cycle wins, so no index change is ever lost
            if (idx_chg || rfsh_hit) pending <= 1'b1;
            else if (launch)         pending <= 1'b0;

            if (idx_chg)            rcnt <= '0;
            else if (state == IDLE) rcnt <= rfsh_hit ? '0 : rcnt + RCW'(1);

            if (launch) begin
                rd_addr <= idx;
                rd_req  <= 1'b1;
                tcnt    <= '0;
            end
            if (ack_hit) begin
                hold   <= rd_data;
                tmo    <= 1'b0;
                rd_req <= 1'b0;
            end
            if (tmo_hit) begin
                tmo    <= 1'b1;
                rd_req <= 1'b0;
            end
            if (state == REQ && !ack_hit && !tmo_hit) tcnt <= tcnt + TCW'(1);

            // display is written on the edge after UPDATE: ack sampled at N -> seg at N+2
            if (upd_q) begin
                seg <= {8'(rd_addr), 8'h00, tmo ? 16'hEEEE : hold};
                err <= tmo;
            end
        end
    end
endmodule
